// File: rtl/clock_gate_ctrl_pkg.sv
// Shared types and defaults for the clock-gate idle/wake sequencer.
package clock_gate_pkg;

   typedef enum logic [1:0] {
      RUN   = 2'd0,
      DRAIN = 2'd1,
      GATED = 2'd2,
      WAKE  = 2'd3
   } cg_state_e;

   localparam int unsigned CG_DEFAULT_IDLE_CYCLES = 16;
   localparam int unsigned CG_DEFAULT_WAKE_CYCLES = 2;
   localparam int unsigned CG_STATS_W             = 32;

endpackage

// File: rtl/clock_gate_ctrl_stats.sv
// Saturating event counter with synchronous clear; clear wins over increment.
module clock_gate_stats
   import clock_gate_pkg::*;
#(
   parameter int unsigned W = CG_STATS_W
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         clr,
   input  logic         inc,
   output logic [W-1:0] count
);

   // Count qualifying cycles, holding at all-ones.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= '0;
      end else if (clr) begin
         count <= '0;
      end else if (inc && (count != '1)) begin
         count <= count + W'(1);
      end
   end

endmodule

// File: rtl/clock_gate_ctrl.sv
// Idle-detect / wake sequencer driving the enable of an external ClockGate.
// Optional gated-cycle statistics counter: define CLOCK_GATE_CTRL_STATS_EN.
module clock_gate_ctrl
   import clock_gate_pkg::*;
#(
   parameter int unsigned NUM_REQ     = 4,
   parameter int unsigned IDLE_CYCLES = CG_DEFAULT_IDLE_CYCLES,
   parameter int unsigned WAKE_CYCLES = CG_DEFAULT_WAKE_CYCLES
) (
   input  logic               clk_i,
   input  logic               rst_ni,
   input  logic [NUM_REQ-1:0] busy_i,
   input  logic [NUM_REQ-1:0] wake_req_i,
   output logic [NUM_REQ-1:0] wake_ack_o,
   input  logic               force_on_i,
   output logic               cg_en_o,
   output logic               gated_o
`ifdef CLOCK_GATE_CTRL_STATS_EN
   ,
   input  logic                  stats_clr_i,
   output logic [CG_STATS_W-1:0] gated_cycles_o
`endif
);

   localparam int unsigned IDLE_W = $clog2(IDLE_CYCLES + 1);
   localparam int unsigned WAKE_W = $clog2(WAKE_CYCLES + 1);
   localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(IDLE_CYCLES - 1);
   localparam logic [WAKE_W-1:0] WAKE_LAST = WAKE_W'(WAKE_CYCLES - 1);

   cg_state_e         state;
   logic [IDLE_W-1:0] idle_cnt;
   logic [WAKE_W-1:0] wake_cnt;
   logic              idle;

   assign idle = ~|busy_i & ~|wake_req_i & ~force_on_i;

   // Sequencer: enable/status are registered alongside the state so the
   // ClockGate enable never sees a combinational path from the inputs.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state    <= RUN;
         cg_en_o  <= 1'b1;
         gated_o  <= 1'b0;
         idle_cnt <= '0;
         wake_cnt <= '0;
      end else begin
         case (state)
            RUN: begin
               if (idle) begin
                  state    <= DRAIN;
                  idle_cnt <= '0;
               end
            end
            DRAIN: begin
               if (!idle) begin
                  state    <= RUN;
                  idle_cnt <= '0;
               end else if (idle_cnt == IDLE_LAST) begin
                  state   <= GATED;
                  cg_en_o <= 1'b0;
                  gated_o <= 1'b1;
               end else begin
                  idle_cnt <= idle_cnt + IDLE_W'(1);
               end
            end
            GATED: begin
               if (!idle) begin
                  state    <= WAKE;
                  wake_cnt <= '0;
                  cg_en_o  <= 1'b1;
                  gated_o  <= 1'b0;
               end
            end
            WAKE: begin
               if (wake_cnt == WAKE_LAST) begin
                  state <= RUN;
               end else begin
                  wake_cnt <= wake_cnt + WAKE_W'(1);
               end
            end
            default: begin
               state   <= RUN;
               cg_en_o <= 1'b1;
               gated_o <= 1'b0;
            end
         endcase
      end
   end

   // Acknowledge is the only input-dependent output: requests pass through in RUN.
   always_comb begin
      wake_ack_o = wake_req_i & {NUM_REQ{state == RUN}};
   end

`ifdef CLOCK_GATE_CTRL_STATS_EN
   clock_gate_stats #(
      .W (CG_STATS_W)
   ) u_stats (
      .clk   (clk_i),
      .rst_n (rst_ni),
      .clr   (stats_clr_i),
      .inc   (~cg_en_o),
      .count (gated_cycles_o)
   );
`else
   // Statistics counter not built.
`endif

endmodule

// File: doc/clock_gate_ctrl.md
Name: clock_gate_ctrl

Overview:
- Idle-detect and wake sequencer that drives the `enable` input of a ClockGate instance placed by the integrating parent.
- Runs on the ungated clock.
- Gates the downstream domain after a programmable run of idle cycles.
- Re-enables the domain on any wake request and returns a per-requester acknowledge once the gated clock has run for WAKE_CYCLES cycles.

Parameters:
- NUM_REQ, 4: number of requesters (width of busy/wake/ack vectors), >=1.
- IDLE_CYCLES, 16: consecutive idle cycles in DRAIN before gating, >=1.
- WAKE_CYCLES, 2: enabled cycles in WAKE before RUN and ack, >=1.

Ports:
- clk_i  input  1  ungated clock; also feeds the ClockGate clk_i.
- rst_ni  input  1  asynchronous active-low reset.
- busy_i  input  NUM_REQ  per-requester activity; must be driven from the ungated domain or held stable while gated.
- wake_req_i  input  NUM_REQ  level wake request; held until the matching ack.
- wake_ack_o  output  NUM_REQ  wake acknowledge.
- force_on_i  input  1  inhibits gating.
- cg_en_o  output  1  to ClockGate enable; 1 = clock passes.
- gated_o  output  1  status: downstream clock currently gated.

Behaviour:
- Reset (async assert, sync-free): state=RUN, cg_en_o=1, gated_o=0, wake_ack_o=0, idle_cnt=0, wake_cnt=0.
- Reset mid-operation returns to RUN with cg_en_o=1 immediately, so reset propagates into the gated domain.
- Definition: idle = ~|busy_i & ~|wake_req_i & ~force_on_i.
- States are cg_state_e {RUN, DRAIN, GATED, WAKE}. All outputs are decoded from registered state, with no input-to-output path except wake_ack_o.
- RUN:
  - cg_en_o=1.
  - If idle: go to DRAIN and clear idle_cnt.
- DRAIN:
  - cg_en_o=1.
  - If not idle: go to RUN and clear idle_cnt.
  - Else if idle_cnt==IDLE_CYCLES-1: go to GATED.
  - Else: increment idle_cnt.
  - Gating therefore occurs after exactly IDLE_CYCLES idle cycles in DRAIN, i.e. IDLE_CYCLES+1 idle cycles from RUN.
- GATED:
  - cg_en_o=0, gated_o=1.
  - If not idle: go to WAKE and clear wake_cnt.
  - cg_en_o rises in the first WAKE cycle, 1 cycle after the request is sampled.
- WAKE:
  - cg_en_o=1, gated_o=0.
  - wake_cnt increments each cycle; at wake_cnt==WAKE_CYCLES-1, go to RUN.
  - WAKE is never aborted, even if all requests drop.
- wake_ack_o[i] = wake_req_i[i] & (state==RUN).
  - Wake request sampled in GATED at cycle t: cg_en_o=1 at t+1, ack at t+1+WAKE_CYCLES.
  - Request asserted in RUN: ack the same cycle.
  - Request in DRAIN: move to RUN, ack next cycle.
- Simultaneous events:
  - Activity in the same cycle as the DRAIN threshold: RUN wins, no gating.
  - force_on_i asserted in any state blocks entry to GATED; in GATED it triggers WAKE.
- Counter widths: idle_cnt is $clog2(IDLE_CYCLES+1) bits and wake_cnt is $clog2(WAKE_CYCLES+1) bits. Neither wraps; both clear on entry to their state.

Optional Feature:
- Macro: CLOCK_GATE_CTRL_STATS_EN.
- When defined, adds two ports:
  - stats_clr_i  input  1.
  - gated_cycles_o  output  32: saturating count of cycles with cg_en_o==0.
- Counter behaviour:
  - Holds at 32'hFFFF_FFFF.
  - stats_clr_i zeroes it the next cycle, taking priority over increment.
  - Resets to 0.
- When undefined: both ports and the counter are absent; behaviour otherwise identical.

Decomposition:
- Package clock_gate_pkg holds:
  - typedef enum logic [1:0] cg_state_e.
  - Localparams CG_DEFAULT_IDLE_CYCLES=16, CG_DEFAULT_WAKE_CYCLES=2.
  - CG_STATS_W=32.
- One sub-module, clock_gate_stats (saturating counter plus clear), instantiated only under the macro.
- ClockGate itself is instantiated by the parent, not inside this block.

Test Plan (IDLE_CYCLES=16, WAKE_CYCLES=2, NUM_REQ=4):
1. Reset with all inputs 0, release at cycle 0: RUN at cycle 0, DRAIN at 1, cg_en_o falls and gated_o rises at cycle 17; held.
2. Idle 10 cycles in DRAIN, then busy_i=4'b0010 for 1 cycle: RUN next cycle, idle_cnt=0. Gating requires a fresh 17 idle cycles.
3. GATED, wake_req_i=4'b0100 at cycle t: cg_en_o=1 at t+1, RUN at t+3, wake_ack_o=4'b0100 at t+3. Drop req at t+4: ack 0 at t+4.
4. force_on_i=1 throughout 100 idle cycles: cg_en_o stays 1. Assert force_on_i while GATED: WAKE next cycle.
5. Assert rst_ni=0 mid-GATED: cg_en_o=1 and gated_o=0 asynchronously; state RUN after release.
6. With CLOCK_GATE_CTRL_STATS_EN: gate for 50 cycles, gated_cycles_o=50. Pulse stats_clr_i: 0 next cycle. Preload near max: saturates at 32'hFFFF_FFFF.
